// File: rtl/docpu_bus_bridge_if.sv
// rtl/docpu_bus_bridge_if.sv - CPU data-port and slave-channel signal bundle for docpu_bus_bridge
//
// Signals (names are from the bridge's point of view):
//   m_ce_i, m_we_i, m_addr_i[31:0], m_sel_i[3:0], m_data_i[31:0]  CPU request
//   m_data_o[31:0], m_stall_o, m_err_o                             CPU response
//   s_ce_o[NUM_SLV-1:0], s_we_o, s_addr_o[31:0], s_sel_o[3:0],
//   s_data_o[31:0]                                                 slave request
//   s_data_i[NUM_SLV*32-1:0], s_ack_i[NUM_SLV-1:0]                 slave response
// Modports:
//   slave  - the bridge itself (serves the CPU, drives the slave channels)
//   master - the environment (CPU plus slave devices)
interface docpu_bus_bridge_if #(
    parameter int NUM_SLV = 2
);
    logic                   m_ce_i;
    logic                   m_we_i;
    logic [31:0]            m_addr_i;
    logic [3:0]             m_sel_i;
    logic [31:0]            m_data_i;
    logic [31:0]            m_data_o;
    logic                   m_stall_o;
    logic                   m_err_o;
    logic [NUM_SLV-1:0]     s_ce_o;
    logic                   s_we_o;
    logic [31:0]            s_addr_o;
    logic [3:0]             s_sel_o;
    logic [31:0]            s_data_o;
    logic [NUM_SLV*32-1:0]  s_data_i;
    logic [NUM_SLV-1:0]     s_ack_i;

    modport slave (
        input  m_ce_i, m_we_i, m_addr_i, m_sel_i, m_data_i, s_data_i, s_ack_i,
        output m_data_o, m_stall_o, m_err_o, s_ce_o, s_we_o, s_addr_o, s_sel_o, s_data_o
    );

    modport master (
        output m_ce_i, m_we_i, m_addr_i, m_sel_i, m_data_i, s_data_i, s_ack_i,
        input  m_data_o, m_stall_o, m_err_o, s_ce_o, s_we_o, s_addr_o, s_sel_o, s_data_o
    );
endinterface

// File: rtl/docpu_bus_bridge.sv
// rtl/docpu_bus_bridge.sv - DoCPU data-port to NUM_SLV memory-mapped slave bridge with ce/ack handshake
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - docpu_bus_bridge_if.slave (CPU request/response and slave channels)
// Parameters:
//   NUM_SLV   - slave channel count (1..8), lower index wins on overlapping windows
//   SLV_BASE  - packed NUM_SLV x 32 window bases, slave 0 in the LSBs
//   SLV_MASK  - packed NUM_SLV x 32 window masks, hit when (addr & mask) == base
//   TIMEOUT   - BUSY cycles without ack before the access is aborted (1..255)
// Build option:
//   BUS_TIMEOUT_EN - when defined, builds the BUSY timeout counter; otherwise BUSY waits for ack forever
module docpu_bus_bridge #(
    parameter int                    NUM_SLV  = 2,
    parameter logic [NUM_SLV*32-1:0] SLV_BASE = {32'hFFFF_0000, 32'h1001_0000},
    parameter logic [NUM_SLV*32-1:0] SLV_MASK = {32'hFFFF_FF00, 32'hFFFF_0000},
    parameter int                    TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                rst,
    docpu_bus_bridge_if.slave   bus
);
    localparam int IW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    if (NUM_SLV < 1 || NUM_SLV > 8) begin : g_bad_num_slv
        $error("docpu_bus_bridge: NUM_SLV must be 1..8");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("docpu_bus_bridge: TIMEOUT must be 1..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t             state;
    logic [IW-1:0]      sel_idx;
    logic [NUM_SLV-1:0] s_ce_q;
    logic               s_we_q;
    logic [31:0]        s_addr_q;
    logic [3:0]         s_sel_q;
    logic [31:0]        s_data_q;
    logic [31:0]        m_data_q;
    logic               m_err_q;

    logic               hit;
    logic [IW-1:0]      hit_idx;
    logic [31:0]        hit_mask;
    logic               sel_ack;
    logic [31:0]        sel_rdata;

`ifdef BUS_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    logic [7:0]         wait_cnt;
`endif

    // Walk from the highest index down so the lowest matching window is the one kept.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_mask = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((bus.m_addr_i & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]) begin
                hit      = 1'b1;
                hit_idx  = IW'(i);
                hit_mask = SLV_MASK[i*32 +: 32];
            end
        end
    end

    // Only the latched slave's ack and data are looked at; other channels are ignored.
    assign sel_ack   = bus.s_ack_i[sel_idx];
    assign sel_rdata = bus.s_data_i[int'(sel_idx)*32 +: 32];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            sel_idx  <= '0;
            s_ce_q   <= '0;
            s_we_q   <= 1'b0;
            s_addr_q <= '0;
            s_sel_q  <= '0;
            s_data_q <= '0;
            m_data_q <= '0;
            m_err_q  <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            wait_cnt <= '0;
`endif
        end else begin
            m_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.m_ce_i) begin
                        if (hit) begin
                            state    <= BUSY;
                            sel_idx  <= hit_idx;
                            s_ce_q   <= NUM_SLV'(1) << hit_idx;
                            s_we_q   <= bus.m_we_i;
                            s_addr_q <= bus.m_addr_i & ~hit_mask;
                            s_sel_q  <= bus.m_sel_i;
                            s_data_q <= bus.m_data_i;
`ifdef BUS_TIMEOUT_EN
                            wait_cnt <= '0;
`endif
                        end else begin
                            // Decode miss: slave outputs keep their previous latch.
                            state   <= ERR;
                            m_err_q <= 1'b1;
                            if (!bus.m_we_i) begin
                                m_data_q <= '0;
                            end
                        end
                    end
                end
                BUSY: begin
                    // Ack is tested first so it wins over a same-cycle timeout.
                    if (sel_ack) begin
                        state  <= DONE;
                        s_ce_q <= '0;
                        if (!s_we_q) begin
                            m_data_q <= sel_rdata;
                        end
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (wait_cnt == WAIT_LAST) begin
                        state   <= ERR;
                        s_ce_q  <= '0;
                        m_err_q <= 1'b1;
                        if (!s_we_q) begin
                            m_data_q <= '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Gated by rst so every output reads 0 while reset is held, even with a request pending.
    assign bus.m_stall_o = rst & (((state == IDLE) & bus.m_ce_i) | (state == BUSY));
    assign bus.m_data_o  = m_data_q;
    assign bus.m_err_o   = m_err_q;
    assign bus.s_ce_o    = s_ce_q;
    assign bus.s_we_o    = s_we_q;
    assign bus.s_addr_o  = s_addr_q;
    assign bus.s_sel_o   = s_sel_q;
    assign bus.s_data_o  = s_data_q;
endmodule

// File: tb/tb_docpu_bus_bridge.sv
// tb/tb_docpu_bus_bridge.sv - self-checking bench for docpu_bus_bridge
module tb_docpu_bus_bridge;
    localparam int          NUM_SLV = 2;
    localparam logic [63:0] BASE    = {32'hFFFF_0000, 32'h1001_0000};
    localparam logic [63:0] MASK    = {32'hFFFF_FF00, 32'hFFFF_0000};
    localparam int          TIMEOUT = 15;
    localparam int          LIMIT   = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    docpu_bus_bridge_if #(.NUM_SLV(NUM_SLV)) bus ();

    docpu_bus_bridge #(
        .NUM_SLV (NUM_SLV),
        .SLV_BASE(BASE),
        .SLV_MASK(MASK),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int                 stalls;
        int                 errs;
        logic [NUM_SLV-1:0] ce;
        logic [31:0]        off;
        logic               we;
        logic [3:0]         sel;
        logic [31:0]        wdata;
        logic [31:0]        mdata;
        bit                 hung;
    } obs_t;

    typedef struct {
        logic               we;
        logic [31:0]        addr;
        logic [3:0]         sel;
        logic [31:0]        wdata;
        int                 delay;
        logic [31:0]        rdata;
        int                 e_stalls;
        int                 e_errs;
        logic [NUM_SLV-1:0] e_ce;
        logic [31:0]        e_off;
        logic [31:0]        e_mdata;
    } vec_t;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] model_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Window rule: first (lowest) slave whose masked address equals its base.
    function automatic void model_decode(input logic [31:0] addr, output bit hit, output int k,
                                         output logic [31:0] off);
        logic [31:0] b, m;
        hit = 1'b0;
        k   = 0;
        off = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            b = BASE[i*32 +: 32];
            m = MASK[i*32 +: 32];
            if (!hit && ((addr & m) == b)) begin
                hit = 1'b1;
                k   = i;
                off = addr & ~m;
            end
        end
    endfunction

    // Entered just after a negedge. Plays CPU and slaves; the selected slave acks in its
    // (delay+1)-th selected cycle (delay < 0: never). foreign=1 acks every unselected slave.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                             input logic [31:0] wdata, input int delay, input logic [31:0] rdata,
                             input bit foreign, output obs_t o);
        int                    busy;
        bit                    fin;
        logic [NUM_SLV-1:0]    ack;
        logic [NUM_SLV*32-1:0] sd;
        busy = 0;
        fin  = 1'b0;
        o.stalls = 0; o.errs = 0; o.ce = '0; o.off = '0; o.we = 1'b0;
        o.sel = '0; o.wdata = '0; o.mdata = '0; o.hung = 1'b0;
        bus.m_ce_i   = 1'b1;
        bus.m_we_i   = we;
        bus.m_addr_i = addr;
        bus.m_sel_i  = sel;
        bus.m_data_i = wdata;
        for (int cyc = 0; cyc < LIMIT && !fin; cyc++) begin
            #1;
            if (bus.m_stall_o) o.stalls++;
            if (bus.m_err_o) o.errs++;
            ack = '0;
            if (bus.s_ce_o != '0) begin
                busy++;
                if (busy == 1) begin
                    o.ce = bus.s_ce_o; o.off = bus.s_addr_o; o.we = bus.s_we_o;
                    o.sel = bus.s_sel_o; o.wdata = bus.s_data_o;
                end
                if (delay >= 0 && busy == delay + 1) ack = bus.s_ce_o;
            end
            if (foreign) ack = ack | ~bus.s_ce_o;
            for (int j = 0; j < NUM_SLV; j++) sd[j*32 +: 32] = bus.s_ce_o[j] ? rdata : ~rdata;
            bus.s_ack_i  = ack;
            bus.s_data_i = sd;
            if (!bus.m_stall_o) begin
                fin     = 1'b1;
                o.mdata = bus.m_data_o;
            end
            @(posedge clk);
            @(negedge clk);
        end
        if (!fin) o.hung = 1'b1;
        bus.s_ack_i = '0;
    endtask

    task automatic check_obs(input string tag, input obs_t o, input int e_stalls, input int e_errs,
                             input logic [NUM_SLV-1:0] e_ce, input logic [31:0] e_off,
                             input logic e_we, input logic [3:0] e_sel, input logic [31:0] e_wdata,
                             input logic [31:0] e_mdata);
        chk({tag, ".completed"}, 32'(o.hung), 32'd0);
        chk({tag, ".stall_cycles"}, 32'(o.stalls), 32'(e_stalls));
        chk({tag, ".err_cycles"}, 32'(o.errs), 32'(e_errs));
        chk({tag, ".s_ce_o"}, 32'(o.ce), 32'(e_ce));
        chk({tag, ".m_data_o"}, o.mdata, e_mdata);
        if (e_ce != '0) begin
            chk({tag, ".s_addr_o"}, o.off, e_off);
            chk({tag, ".s_we_o"}, 32'(o.we), 32'(e_we));
            chk({tag, ".s_sel_o"}, 32'(o.sel), 32'(e_sel));
            chk({tag, ".s_data_o"}, o.wdata, e_wdata);
        end
    endtask

    vec_t tbl[6];
    obs_t o, o2;

    initial begin
        bit                 hit;
        int                 k;
        logic [31:0]        off;
        logic               we;
        logic [31:0]        addr, wdata, rdata, e_md;
        logic [3:0]         sel;
        int                 delay;
        bit                 foreign;
        logic [NUM_SLV-1:0] e_ce;

        tbl[0] = '{1'b0, 32'h1001_0008, 4'hF, 32'h0000_0000, 0, 32'hCAFE_F00D, 2, 0, 2'b01, 32'h0000_0008, 32'hCAFE_F00D};
        tbl[1] = '{1'b1, 32'hFFFF_0010, 4'b0011, 32'hA5A5_1234, 3, 32'h0BAD_0BAD, 5, 0, 2'b10, 32'h0000_0010, 32'hCAFE_F00D};
        tbl[2] = '{1'b0, 32'h0040_0000, 4'hF, 32'h0000_0000, 0, 32'h1111_1111, 1, 1, 2'b00, 32'h0, 32'h0000_0000};
        tbl[3] = '{1'b0, 32'hFFFF_00FC, 4'hF, 32'h0000_0000, 1, 32'h1234_5678, 3, 0, 2'b10, 32'h0000_00FC, 32'h1234_5678};
        tbl[4] = '{1'b1, 32'h1001_FFFC, 4'b1100, 32'h0F0F_F0F0, 0, 32'h7777_7777, 2, 0, 2'b01, 32'h0000_FFFC, 32'h1234_5678};
        tbl[5] = '{1'b1, 32'hFFFF_0100, 4'hF, 32'hDEAD_0001, 0, 32'h8888_8888, 1, 1, 2'b00, 32'h0, 32'h1234_5678};

        bus.m_ce_i = 1'b1; bus.m_we_i = 1'b0; bus.m_addr_i = 32'h1001_0000;
        bus.m_sel_i = 4'hF; bus.m_data_i = 32'h5555_AAAA;
        bus.s_ack_i = '1; bus.s_data_i = '1;

        // Reset held three cycles with a request pending.
        repeat (3) @(negedge clk);
        #1;
        chk("reset.m_data_o", bus.m_data_o, 32'h0);
        chk("reset.m_stall_o", 32'(bus.m_stall_o), 32'h0);
        chk("reset.m_err_o", 32'(bus.m_err_o), 32'h0);
        chk("reset.s_ce_o", 32'(bus.s_ce_o), 32'h0);
        chk("reset.s_we_o", 32'(bus.s_we_o), 32'h0);
        chk("reset.s_addr_o", bus.s_addr_o, 32'h0);
        chk("reset.s_sel_o", 32'(bus.s_sel_o), 32'h0);
        chk("reset.s_data_o", bus.s_data_o, 32'h0);
        bus.m_ce_i = 1'b0;
        bus.s_ack_i = '0;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_access(tbl[i].we, tbl[i].addr, tbl[i].sel, tbl[i].wdata, tbl[i].delay, tbl[i].rdata, 1'b0, o);
            check_obs($sformatf("vec%0d", i), o, tbl[i].e_stalls, tbl[i].e_errs, tbl[i].e_ce, tbl[i].e_off,
                      tbl[i].we, tbl[i].sel, tbl[i].wdata, tbl[i].e_mdata);
            bus.m_ce_i = 1'b0;
            #1;
            chk($sformatf("vec%0d.err_after", i), 32'(bus.m_err_o), 32'h0);
            @(negedge clk);
        end

        // Reset in the middle of a BUSY access: select drops at once, no error follows.
        bus.m_ce_i = 1'b1; bus.m_we_i = 1'b0; bus.m_addr_i = 32'h1001_0004;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("midrst.busy_ce", 32'(bus.s_ce_o), 32'h1);
        rst = 1'b0;
        #1;
        chk("midrst.s_ce_o", 32'(bus.s_ce_o), 32'h0);
        chk("midrst.m_stall_o", 32'(bus.m_stall_o), 32'h0);
        chk("midrst.m_data_o", bus.m_data_o, 32'h0);
        bus.m_ce_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("midrst.err_after", 32'(bus.m_err_o), 32'h0);
            chk("midrst.stall_after", 32'(bus.m_stall_o), 32'h0);
        end
        @(negedge clk);

        // Back-to-back reads on slave 0 while slave 1 keeps acking.
        do_access(1'b0, 32'h1001_0010, 4'hF, 32'h0, 0, 32'h1111_2222, 1'b1, o);
        do_access(1'b0, 32'h1001_0020, 4'hF, 32'h0, 0, 32'h3333_4444, 1'b1, o2);
        chk("b2b.first_data", o.mdata, 32'h1111_2222);
        chk("b2b.second_data", o2.mdata, 32'h3333_4444);
        chk("b2b.total_stall", 32'(o.stalls + o2.stalls), 32'd4);
        chk("b2b.errs", 32'(o.errs + o2.errs), 32'd0);
        model_rdata = 32'h3333_4444;
        bus.m_ce_i = 1'b0;
        @(negedge clk);

        // Randomized accesses against the window/latency model.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 2))
                0:       addr = {16'h1001, 16'($urandom)};
                1:       addr = {24'hFFFF_00, 8'($urandom)};
                default: addr = $urandom;
            endcase
            we      = 1'($urandom);
            sel     = 4'($urandom);
            wdata   = $urandom;
            rdata   = $urandom;
            delay   = $urandom_range(0, 3);
            foreign = 1'($urandom);
            model_decode(addr, hit, k, off);
            if (hit) begin
                e_ce = NUM_SLV'(1) << k;
                e_md = we ? model_rdata : rdata;
            end else begin
                e_ce = '0;
                e_md = we ? model_rdata : 32'h0;
            end
            do_access(we, addr, sel, wdata, delay, rdata, foreign, o);
            check_obs($sformatf("rnd%0d", n), o, hit ? 2 + delay : 1, hit ? 0 : 1, e_ce, off, we, sel, wdata, e_md);
            model_rdata = e_md;
            if ($urandom_range(0, 1) == 1) begin
                bus.m_ce_i = 1'b0;
                @(negedge clk);
            end
        end
        bus.m_ce_i = 1'b0;
        @(negedge clk);

`ifdef BUS_TIMEOUT_EN
        do_access(1'b0, 32'h1001_0030, 4'hF, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, o);
        chk("to.pre_data", o.mdata, 32'hDEAD_BEEF);
        bus.m_ce_i = 1'b0;
        @(negedge clk);
        do_access(1'b0, 32'h1001_0040, 4'hF, 32'h0, -1, 32'h0, 1'b1, o);
        check_obs("timeout", o, TIMEOUT + 1, 1, 2'b01, 32'h0040, 1'b0, 4'hF, 32'h0, 32'h0);
        bus.m_ce_i = 1'b0;
        @(negedge clk);
        do_access(1'b0, 32'h1001_0044, 4'hF, 32'h0, TIMEOUT - 1, 32'h5A5A_A5A5, 1'b0, o);
        check_obs("ack_vs_timeout", o, TIMEOUT + 1, 0, 2'b01, 32'h0044, 1'b0, 4'hF, 32'h0, 32'h5A5A_A5A5);
        bus.m_ce_i = 1'b0;
        @(negedge clk);
        do_access(1'b1, 32'hFFFF_0020, 4'h1, 32'h0000_00AB, 0, 32'h0, 1'b0, o);
        check_obs("after_timeout", o, 2, 0, 2'b10, 32'h0020, 1'b1, 4'h1, 32'h0000_00AB, 32'h5A5A_A5A5);
        bus.m_ce_i = 1'b0;
        @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/docpu_bus_bridge.md
# docpu_bus_bridge

Parametrised data-bus bridge between the DoCPU data-memory port and NUM_SLV memory-mapped slaves (data RAM, timer, I/O). It replaces the direct CPU-to-dmem hookup in the core top. It decodes each access against per-slave address windows and forwards it with a ce/ack handshake. It stalls the CPU until the slave acknowledges, and reports decode misses and timeouts as a one-cycle error pulse.

## Interface
- NUM_SLV, 2, number of slave channels (1..8); lower index wins on overlapping windows
- SLV_BASE, {32'hFFFF_0000, 32'h1001_0000}, packed NUM_SLV×32 window bases, slave 0 in the LSBs
- SLV_MASK, {32'hFFFF_FF00, 32'hFFFF_0000}, packed NUM_SLV×32 window masks; hit when (addr & mask) == base
- TIMEOUT, 15, maximum BUSY cycles before the access is aborted (1..255)
- clk  in  1  system clock, all state on the rising edge
- rst  in  1  asynchronous, active-low reset
- m_ce_i  in  1  CPU access request; held stable while m_stall_o=1
- m_we_i  in  1  1=write, 0=read
- m_addr_i  in  32  byte address
- m_sel_i  in  4  byte enables
- m_data_i  in  32  write data
- m_data_o  out  32  read data
- m_stall_o  out  1  CPU pipeline hold
- m_err_o  out  1  one-cycle error pulse
- s_ce_o  out  NUM_SLV  one-hot slave select
- s_we_o  out  1  latched write enable
- s_addr_o  out  32  slave-relative offset = addr & ~mask
- s_sel_o  out  4  latched byte enables
- s_data_o  out  32  latched write data
- s_data_i  in  NUM_SLV×32  packed slave read data
- s_ack_i  in  NUM_SLV  slave completion, sampled on the clock edge

## Operation
- The FSM has four states: IDLE, BUSY, DONE, ERR.
- IDLE, m_ce_i=1, window hit on slave k: latch we/addr offset/sel/data/k, clear the counter, go to BUSY.
- IDLE, m_ce_i=1, no window hit: go to ERR.
- IDLE, m_ce_i=0: stay in IDLE.
- BUSY: s_ce_o[k]=1 and the latched fields drive the slave outputs.
  - s_ack_i[k]=1: for a read, capture s_data_i[k] into m_data_o; go to DONE.
  - No ack: the counter increments; when it reaches TIMEOUT, go to ERR.
  - Acks from non-selected slaves are ignored.
- DONE: go to IDLE unconditionally.
- ERR: m_err_o=1; for a read, m_data_o is set to 0; go to IDLE.
- m_stall_o = (IDLE & m_ce_i) | BUSY, computed combinationally. It is 0 in DONE and ERR, so the CPU advances at the end of that cycle.
- m_data_o holds its value until the next read completes or errors. A write never changes m_data_o.
- A back-to-back request is seen in the IDLE cycle that follows DONE.
- s_ce_o is registered from the state. Slave outputs other than s_ce_o hold their last latched value when idle.
- Address alignment against m_sel_i is not checked; sel is passed through unchanged.

## Timing
- All outputs reset to 0 and the state resets to IDLE. Reset takes effect asynchronously on rst falling and releases on the first edge after rst rises.
- A reset mid-access drops s_ce_o immediately; the access is lost and no error is raised.
- Minimum access: request seen in cycle 0, s_ce_o high in cycle 1, ack sampled at the end of cycle 1, DONE in cycle 2.
  - Stall is high in cycles 0 and 1.
  - Read data is valid in m_data_o from cycle 2.
- An ack delayed by n cycles adds n stall cycles.
- Timeout: ERR follows the TIMEOUT-th BUSY cycle without an ack. The total stall is TIMEOUT+1 cycles.
- A decode miss gives a 1-cycle stall (cycle 0) and ERR in cycle 1.
- If ack and timeout occur in the same cycle, ack wins.

## Configuration
- BUS_TIMEOUT_EN defined: the timeout counter and the timeout-to-ERR transition are built as described.
- BUS_TIMEOUT_EN undefined: the counter is removed and BUSY waits indefinitely for ack. The TIMEOUT parameter is ignored. Decode-miss errors are unchanged.

## Test plan
- Reset: hold rst=0 for 3 cycles with m_ce_i=1 → all outputs 0, s_ce_o=0; release, first access proceeds normally.
- Read to 0x1001_0008, slave 0 acks in the first BUSY cycle with 0xCAFE_F00D:
  - s_ce_o=2'b01, s_addr_o=0x0008;
  - stall high for 2 cycles;
  - m_data_o=0xCAFE_F00D in the DONE cycle.
- Write 0xA5A5_1234, sel=4'b0011, to 0xFFFF_0010; slave 1 acks after 3 cycles:
  - s_ce_o=2'b10, s_addr_o=0x10, s_sel_o=0011, s_data_o=0xA5A5_1234;
  - stall high for 5 cycles;
  - m_data_o unchanged.
- Read to 0x0040_0000 → decode miss: stall 1 cycle, m_err_o pulses 1 cycle, m_data_o=0, s_ce_o stays 0.
- BUS_TIMEOUT_EN defined, TIMEOUT=15, slave 0 never acks → stall high 16 cycles, then m_err_o pulses, m_data_o=0; the next access works normally.
- Two back-to-back reads with ack on the first BUSY cycle → 4 stall cycles total. The second read's data replaces the first in m_data_o. Late ack from slave 1 while slave 0 is selected is ignored.
